// File: rtl/ball_locator.sv
// Finds a coloured ball in a raster pixel stream: accumulates ball-pixel coordinates per frame,
// then divides to get the centroid. Optional output smoothing under BALL_LOCATOR_SMOOTH_EN.
module ball_locator #(
    parameter int          H_ACTIVE  = 1024,
    parameter int          V_ACTIVE  = 768,
    parameter logic [3:0]  R_MIN     = 4'hC,
    parameter logic [3:0]  G_MAX     = 4'h4,
    parameter logic [3:0]  B_MAX     = 4'h4,
    parameter int          MIN_COUNT = 16,
    parameter int          RADIUS    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [11:0] pixel_in,
    input  logic        pixel_valid,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        found,
    output logic        loc_valid,
    output logic        busy
);

    typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

    // One restoring-division step: returns {quotient_bit, new_remainder}.
    function automatic logic [20:0] div_step(input logic [19:0] rem, input logic msb,
                                             input logic [19:0] divisor);
        logic [20:0] trial;
        logic [20:0] dext;
        trial = {rem, msb};
        dext  = {1'b0, divisor};
        if (trial >= dext) begin
            div_step = {1'b1, 20'(trial - dext)};
        end else begin
            div_step = {1'b0, trial[19:0]};
        end
    endfunction

    // Centroid to top-left corner, clamped at the screen edge.
    function automatic logic [29:0] sub_clamp(input logic [29:0] q);
        if (q < 30'(RADIUS)) begin
            sub_clamp = 30'd0;
        end else begin
            sub_clamp = q - 30'(RADIUS);
        end
    endfunction

    state_t      state_r;
    logic [29:0] sum_x_r, sum_y_r;
    logic [19:0] count_r;
    logic [29:0] quo_x_r, quo_y_r;
    logic [19:0] rem_x_r, rem_y_r;
    logic [19:0] div_r;
    logic [4:0]  iter_r;

    logic        ball_s, frame_end_s;
    logic [29:0] snap_x_s, snap_y_s;
    logic [19:0] snap_cnt_s;
    logic [20:0] step_x_s, step_y_s;
    logic [10:0] x_new_s;
    logic [9:0]  y_new_s;
    logic [29:0] clamp_x_s, clamp_y_s;

    assign ball_s = pixel_valid && (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE)) &&
                    (pixel_in[11:8] >= R_MIN) && (pixel_in[7:4] <= G_MAX) &&
                    (pixel_in[3:0] <= B_MAX);
    assign frame_end_s = pixel_valid && (hcount == H_LAST) && (vcount == V_LAST);

    // The frame-end pixel itself belongs to the snapshot handed to the divider.
    assign snap_x_s   = sum_x_r + (ball_s ? {19'd0, hcount} : 30'd0);
    assign snap_y_s   = sum_y_r + (ball_s ? {20'd0, vcount} : 30'd0);
    assign snap_cnt_s = count_r + (ball_s ? 20'd1 : 20'd0);

    assign step_x_s  = div_step(rem_x_r, quo_x_r[29], div_r);
    assign step_y_s  = div_step(rem_y_r, quo_y_r[29], div_r);
    assign clamp_x_s = sub_clamp(quo_x_r);
    assign clamp_y_s = sub_clamp(quo_y_r);
    assign x_new_s   = clamp_x_s[10:0];
    assign y_new_s   = clamp_y_s[9:0];

`ifdef BALL_LOCATOR_SMOOTH_EN
    logic [11:0] x_sum_s;
    logic [10:0] y_sum_s;
    assign x_sum_s = {1'b0, x_out} + {1'b0, x_new_s};
    assign y_sum_s = {1'b0, y_out} + {1'b0, y_new_s};
`endif

    // Accumulation, divider sequencing and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ACCUM;
            sum_x_r   <= 30'd0;
            sum_y_r   <= 30'd0;
            count_r   <= 20'd0;
            quo_x_r   <= 30'd0;
            quo_y_r   <= 30'd0;
            rem_x_r   <= 20'd0;
            rem_y_r   <= 20'd0;
            div_r     <= 20'd0;
            iter_r    <= 5'd0;
            x_out     <= 11'd0;
            y_out     <= 10'd0;
            found     <= 1'b0;
            loc_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            loc_valid <= 1'b0;
            // Accumulators clear on every frame end, even when the snapshot is dropped.
            if (frame_end_s) begin
                sum_x_r <= 30'd0;
                sum_y_r <= 30'd0;
                count_r <= 20'd0;
            end else if (ball_s) begin
                sum_x_r <= snap_x_s;
                sum_y_r <= snap_y_s;
                count_r <= snap_cnt_s;
            end else begin
                count_r <= count_r;
            end

            case (state_r)
                ACCUM: begin
                    if (frame_end_s) begin
                        quo_x_r <= snap_x_s;
                        quo_y_r <= snap_y_s;
                        rem_x_r <= 20'd0;
                        rem_y_r <= 20'd0;
                        div_r   <= snap_cnt_s;
                        iter_r  <= 5'd0;
                        busy    <= 1'b1;
                        state_r <= DIVIDE;
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                DIVIDE: begin
                    quo_x_r <= {quo_x_r[28:0], step_x_s[20]};
                    quo_y_r <= {quo_y_r[28:0], step_y_s[20]};
                    rem_x_r <= step_x_s[19:0];
                    rem_y_r <= step_y_s[19:0];
                    iter_r  <= iter_r + 5'd1;
                    if (iter_r == 5'd29) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= DIVIDE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    loc_valid <= 1'b1;
                    state_r   <= ACCUM;
                    if (div_r >= 20'(MIN_COUNT)) begin
                        found <= 1'b1;
`ifdef BALL_LOCATOR_SMOOTH_EN
                        if (found) begin
                            x_out <= x_sum_s[11:1];
                            y_out <= y_sum_s[10:1];
                        end else begin
                            x_out <= x_new_s;
                            y_out <= y_new_s;
                        end
`else
                        x_out <= x_new_s;
                        y_out <= y_new_s;
`endif
                    end else begin
                        found <= 1'b0;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_locator.sv
// Directed bench for ball_locator on a 16x12 raster with hand-computed centroids.
module tb_ball_locator;

    logic        clock;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [11:0] pixel_in;
    logic        pixel_valid;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        found;
    logic        loc_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ball_locator #(
        .H_ACTIVE(16), .V_ACTIVE(12), .R_MIN(4'hC), .G_MAX(4'h4), .B_MAX(4'h4),
        .MIN_COUNT(4), .RADIUS(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .x_out(x_out), .y_out(y_out),
        .found(found), .loc_valid(loc_valid), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full frame; the ball rectangle gets pixel_valid = ball_valid, everything else is background.
    task automatic send_frame(input int x0, input int x1, input int y0, input int y1,
                              input logic ball_valid);
        for (int v = 0; v < 12; v++) begin
            for (int h = 0; h < 16; h++) begin
                logic in_ball;
                in_ball     = (h >= x0) && (h <= x1) && (v >= y0) && (v <= y1);
                hcount      = 11'(h);
                vcount      = 10'(v);
                pixel_in    = in_ball ? 12'hF00 : 12'h000;
                pixel_valid = in_ball ? ball_valid : 1'b1;
                tick();
            end
        end
        pixel_valid = 1'b0;
        pixel_in    = 12'h000;
    endtask

    // Called just after E0; checks busy over E1..E30, then the result and a single-cycle loc_valid.
    task automatic wait_result(input logic exp_found, input int exp_x, input int exp_y,
                               input int inject, input string name);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_e0: got %b want 1", name, busy);
        end
        for (int i = 1; i <= 30; i++) begin
            if (i == inject) begin
                hcount = 11'd15; vcount = 10'd11; pixel_in = 12'hF00; pixel_valid = 1'b1;
            end
            tick();
            pixel_valid = 1'b0;
            n_checks++;
            if (busy !== 1'b1 || loc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_e%0d: got busy=%b loc_valid=%b want 1/0", name, i, busy, loc_valid);
            end
        end
        tick();
        n_checks++;
        if (loc_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s e31_flags: got loc_valid=%b busy=%b want 1/0", name, loc_valid, busy);
        end
        n_checks++;
        if (found !== exp_found || x_out !== 11'(exp_x) || y_out !== 10'(exp_y)) begin
            n_fail++;
            $display("FAIL %s result: got found=%b x=%0d y=%0d want found=%b x=%0d y=%0d",
                     name, found, x_out, y_out, exp_found, exp_x, exp_y);
        end
        tick();
        n_checks++;
        if (loc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse_width: got loc_valid=%b want 0", name, loc_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hcount = 11'd0; vcount = 10'd0; pixel_in = 12'h000; pixel_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (x_out !== 11'd0 || y_out !== 10'd0 || found !== 1'b0 || loc_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got x=%0d y=%0d found=%b lv=%b busy=%b want all 0",
                     x_out, y_out, found, loc_valid, busy);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ball();
        send_frame(5, 7, 4, 6, 1'b1);
        wait_result(1'b1, 4, 3, 0, "ball3x3");
    endtask

    task automatic test_background();
        send_frame(20, 20, 20, 20, 1'b1);
        wait_result(1'b0, 4, 3, 0, "background");
    endtask

    task automatic test_clamp();
        send_frame(0, 1, 0, 1, 1'b1);
        wait_result(1'b1, 0, 0, 0, "clamp");
    endtask

    task automatic test_invalid();
        send_frame(5, 7, 4, 6, 1'b0);
        wait_result(1'b0, 0, 0, 0, "invalid");
    endtask

    task automatic test_frame_end_pixel();
        send_frame(14, 15, 10, 11, 1'b1);
        wait_result(1'b1, 12, 8, 0, "frame_end_px");
        send_frame(20, 20, 20, 20, 1'b1);
        wait_result(1'b0, 12, 8, 0, "background2");
    endtask

    // A stray frame end mid-divide must be dropped yet still clear the accumulators.
    task automatic test_back_to_back();
        send_frame(5, 7, 4, 6, 1'b1);
        wait_result(1'b1, 4, 3, 5, "b2b_first");
        send_frame(0, 1, 0, 1, 1'b1);
`ifdef BALL_LOCATOR_SMOOTH_EN
        wait_result(1'b1, 2, 1, 0, "b2b_second");
`else
        wait_result(1'b1, 0, 0, 0, "b2b_second");
`endif
    endtask

    task automatic test_reset_mid_divide();
        send_frame(5, 7, 4, 6, 1'b1);
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (x_out !== 11'd0 || y_out !== 10'd0 || found !== 1'b0 || loc_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got x=%0d y=%0d found=%b lv=%b busy=%b want all 0",
                     x_out, y_out, found, loc_valid, busy);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_checks++;
            if (loc_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_pulse cycle %0d: got lv=%b busy=%b want 0/0", i, loc_valid, busy);
            end
        end
        send_frame(5, 7, 4, 6, 1'b1);
        wait_result(1'b1, 4, 3, 0, "after_reset");
    endtask

`ifdef BALL_LOCATOR_SMOOTH_EN
    task automatic test_smooth();
        send_frame(11, 13, 4, 6, 1'b1);
        wait_result(1'b1, 7, 3, 0, "smooth");
    endtask
`endif

    initial begin
        test_reset();
        test_ball();
        test_background();
        test_clamp();
        test_invalid();
        test_frame_end_pixel();
        test_back_to_back();
        test_reset_mid_divide();
`ifdef BALL_LOCATOR_SMOOTH_EN
        test_smooth();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
